// File: rtl/bit_serial_adder.sv
// Bit-serial signed adder: one full-adder slice, one bit per clock.
// Computes the exact SIZE+1-bit sign-extended sum of a and b plus a signed
// overflow flag, with valid/ready handshakes on both operand and result sides.
module bit_serial_adder #(
   parameter int unsigned SIZE = 8
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [SIZE-1:0] a,
   input  logic [SIZE-1:0] b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [SIZE:0]   result,
   output logic            overflow
);

   localparam int unsigned CntW = $clog2(SIZE + 1);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e          state_q, state_d;
   logic [SIZE:0]   a_sr_q, b_sr_q;
   logic [SIZE:0]   result_q;
   logic            carry_q;
   logic            overflow_q;
   logic [CntW-1:0] cnt_q;

   logic            accept;
   logic            running;
   logic            last_bit;
   logic            sum_bit;
   logic            carry_nxt;

   assign accept    = (state_q == StIdle) && in_valid;
   assign running   = (state_q == StRun);
   assign last_bit  = running && (cnt_q == CntW'(SIZE));

   // Single full-adder slice working on the current LSBs.
   assign sum_bit   = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
   assign carry_nxt = (a_sr_q[0] & b_sr_q[0]) | (a_sr_q[0] & carry_q) | (b_sr_q[0] & carry_q);

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: if (in_valid)  state_d = StRun;
         StRun:  if (last_bit)  state_d = StDone;
         StDone: if (out_ready) state_d = StIdle;
         default:               state_d = StIdle;
      endcase
   end

   // Handshake outputs decoded from state.
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      unique case (state_q)
         StIdle:  in_ready  = 1'b1;
         StDone:  out_valid = 1'b1;
         default: ;
      endcase
   end

   // Datapath: operand capture, serial add, result shift-in, overflow capture.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         a_sr_q     <= '0;
         b_sr_q     <= '0;
         result_q   <= '0;
         carry_q    <= 1'b0;
         overflow_q <= 1'b0;
         cnt_q      <= '0;
      end else if (accept) begin
         a_sr_q  <= {a[SIZE-1], a};
         b_sr_q  <= {b[SIZE-1], b};
         carry_q <= 1'b0;
         cnt_q   <= '0;
      end else if (running) begin
         a_sr_q   <= {1'b0, a_sr_q[SIZE:1]};
         b_sr_q   <= {1'b0, b_sr_q[SIZE:1]};
         // Sum bits enter at the top; the first (LSB) bit lands at bit 0 after SIZE+1 shifts.
         result_q <= {sum_bit, result_q[SIZE:1]};
         carry_q  <= carry_nxt;
         cnt_q    <= cnt_q + CntW'(1);
         // On the final shift the new bit SIZE-1 is the current bit SIZE.
         if (last_bit) begin
            overflow_q <= sum_bit ^ result_q[SIZE];
         end
      end
   end

   assign result   = result_q;
   assign overflow = overflow_q;

endmodule
